aes_capture_sequencer: RTL and testbench

Campaign controller that drives the AES encryption core in the side-channel capture setup through the core's Kin/Din/Krdy/Drdy/Kvld/Dvld/EN/BSY handshake. It loads one key, then runs a programmed number of encryptions, using either a fixed plaintext or chaining each ciphertext into the next plaintext. Around every encryption it raises a scope trigger, and it inserts a programmable re-arm gap between encryptions. It sits between the host command interface and the AES core.

---
 rtl/aes_seq_pkg.sv | 18 +
 rtl/seq_down_counter.sv | 26 ++
 rtl/aes_capture_sequencer.sv | 164 ++++++++++++++++
 tb/tb_aes_capture_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and defaults for the AES capture campaign sequencer.
package aes_seq_pkg;

    localparam int TIMEOUT_DEFAULT = 1024;

    typedef logic [127:0] block_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_KEY_LOAD   = 3'd1,
        S_KEY_WAIT   = 3'd2,
        S_DATA_ISSUE = 3'd3,
        S_DATA_WAIT  = 3'd4,
        S_GAP        = 3'd5,
        S_DONE       = 3'd6
    } seq_state_e;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; saturates at zero, load wins over decrement.
module seq_down_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge CLK) begin
        if (!RSTn)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/aes_capture_sequencer.sv
// Campaign controller: loads one key into the AES core, then runs num_enc
// encryptions with scope trigger framing and a programmable re-arm gap.
module aes_capture_sequencer
    import aes_seq_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int GAP_W   = 16,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             start,
    input  logic             abort,
    input  logic [127:0]     key,
    input  logic [127:0]     pt_seed,
    input  logic [CNT_W-1:0] num_enc,
    input  logic             chain_mode,
    input  logic [GAP_W-1:0] gap_cycles,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] enc_count,
    output logic [127:0]     ct_last,
    output logic             trigger,
    output logic             err_timeout,
    output logic             core_en,
    output logic [127:0]     core_kin,
    output logic             core_krdy,
    input  logic             core_kvld,
    output logic [127:0]     core_din,
    output logic             core_drdy,
    input  logic [127:0]     core_dout,
    input  logic             core_dvld,
    input  logic             core_bsy
);

    localparam int              WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    seq_state_e       state, state_d;
    block_t           key_q, pt_q;
    logic [CNT_W-1:0] num_q, cnt_inc;
    logic [GAP_W-1:0] gap_q;
    logic             chain_q, drdy_q;

    logic accept, issue, dvld_ok, last_enc, in_wait, wd_expire;
    logic gap_load, wd_load, gap_zero, wd_zero;

    assign accept    = (state == S_IDLE) && start && !abort;
    assign issue     = (state == S_DATA_ISSUE) && !core_bsy;
    assign dvld_ok   = (state == S_DATA_WAIT) && core_dvld;
    assign cnt_inc   = enc_count + CNT_W'(1);
    assign last_enc  = (cnt_inc == num_q);
    assign in_wait   = (state == S_KEY_WAIT) || (state == S_DATA_WAIT);
    // A handshake arriving on the expiry cycle wins over the watchdog.
    assign wd_expire = wd_zero && (((state == S_KEY_WAIT) && !core_kvld) ||
                                   ((state == S_DATA_WAIT) && !core_dvld));
    assign gap_load  = dvld_ok && !last_enc && (gap_q != '0);
    assign wd_load   = (state == S_KEY_LOAD) || issue;

    // Loaded with N-1 so the zero flag marks the N-th cycle in the state.
    seq_down_counter #(.W(GAP_W)) u_gap_cnt (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .load     (gap_load),
        .load_val (gap_q - GAP_W'(1)),
        .dec      (state == S_GAP),
        .zero     (gap_zero)
    );

    seq_down_counter #(.W(WD_W)) u_wd_cnt (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .load     (wd_load),
        .load_val (WD_LOAD),
        .dec      (in_wait),
        .zero     (wd_zero)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d   = state;
        busy      = (state != S_IDLE);
        core_en   = (state != S_IDLE);
        core_krdy = (state == S_KEY_LOAD);
        done      = (state == S_DONE) && !abort;
        unique case (state)
            S_IDLE:       if (accept) state_d = (num_enc == '0) ? S_DONE : S_KEY_LOAD;
            S_KEY_LOAD:   state_d = S_KEY_WAIT;
            S_KEY_WAIT: begin
                if (core_kvld)      state_d = S_DATA_ISSUE;
                else if (wd_expire) state_d = S_DONE;
            end
            S_DATA_ISSUE: if (!core_bsy) state_d = S_DATA_WAIT;
            S_DATA_WAIT: begin
                if (core_dvld) begin
                    if (last_enc)          state_d = S_DONE;
                    else if (gap_q == '0)  state_d = S_DATA_ISSUE;
                    else                   state_d = S_GAP;
                end else if (wd_expire) begin
                    state_d = S_DONE;
                end
            end
            S_GAP:        if (gap_zero) state_d = S_DATA_ISSUE;
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
        if (abort && (state != S_IDLE))
            state_d = S_IDLE;
    end

    // core_drdy and trigger are both set by the issue decision, so the core
    // sees data-ready in the first DATA_WAIT cycle, aligned with the trigger edge.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            key_q       <= '0;
            pt_q        <= '0;
            num_q       <= '0;
            gap_q       <= '0;
            chain_q     <= 1'b0;
            drdy_q      <= 1'b0;
            enc_count   <= '0;
            ct_last     <= '0;
            err_timeout <= 1'b0;
            trigger     <= 1'b0;
        end else begin
            drdy_q <= issue && !abort;
            if (accept) begin
                key_q       <= key;
                pt_q        <= pt_seed;
                num_q       <= num_enc;
                gap_q       <= gap_cycles;
                chain_q     <= chain_mode;
                enc_count   <= '0;
                err_timeout <= 1'b0;
            end else if (abort) begin
                trigger <= 1'b0;
            end else begin
                if (dvld_ok) begin
                    ct_last   <= core_dout;
                    enc_count <= cnt_inc;
                    if (chain_q)
                        pt_q <= core_dout;
                end
                if (wd_expire)
                    err_timeout <= 1'b1;
                if (issue)
                    trigger <= 1'b1;
                else if (dvld_ok || wd_expire)
                    trigger <= 1'b0;
            end
        end
    end

    assign core_kin  = key_q;
    assign core_din  = pt_q;
    assign core_drdy = drdy_q;

endmodule

// File: tb/tb_aes_capture_sequencer.sv
// Directed bench for aes_capture_sequencer with a behavioural AES core stand-in
// and a din/ciphertext scoreboard.
module tb_aes_capture_sequencer;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic         start = 1'b0, abort = 1'b0, chain_mode = 1'b0;
    logic [127:0] key = '0, pt_seed = '0;
    logic [15:0]  num_enc = '0, gap_cycles = '0;
    logic         busy, done, trigger, err_timeout, core_en, core_krdy, core_drdy;
    logic [15:0]  enc_count;
    logic [127:0] ct_last, core_kin, core_din;
    logic         core_kvld = 1'b0, core_dvld = 1'b0, core_bsy = 1'b0;
    logic [127:0] core_dout = '0;

    always #5 CLK = ~CLK;

    aes_capture_sequencer #(.CNT_W(16), .GAP_W(16), .TIMEOUT(16)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort), .key(key),
        .pt_seed(pt_seed), .num_enc(num_enc), .chain_mode(chain_mode),
        .gap_cycles(gap_cycles), .busy(busy), .done(done), .enc_count(enc_count),
        .ct_last(ct_last), .trigger(trigger), .err_timeout(err_timeout),
        .core_en(core_en), .core_kin(core_kin), .core_krdy(core_krdy),
        .core_kvld(core_kvld), .core_din(core_din), .core_drdy(core_drdy),
        .core_dout(core_dout), .core_dvld(core_dvld), .core_bsy(core_bsy)
    );

    int passed = 0, total = 0, failed = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Stand-in cipher: exact FIPS-197 answer for the reference block, otherwise a keyed mix.
    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return {p[94:0], p[127:95]} ^ k ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    // Core model: kvld 3 cycles after krdy, dvld lat+1 cycles after drdy.
    int           lat = 3;
    bit           stall = 1'b0;
    int           kcnt = 0, dcnt = 0;
    logic [127:0] kq = '0, dq = '0;

    always @(posedge CLK) begin
        core_kvld <= 1'b0;
        core_dvld <= 1'b0;
        if (core_krdy) begin
            kq   <= core_kin;
            kcnt <= 2;
        end else if (kcnt > 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) core_kvld <= 1'b1;
        end
        if (core_drdy) begin
            dq       <= core_din;
            core_bsy <= 1'b1;
            dcnt     <= lat;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
                core_bsy <= 1'b0;
                if (!stall) begin
                    core_dvld <= 1'b1;
                    core_dout <= aes_model(kq, dq);
                end
            end
        end
    end

    logic [127:0] exp_din[$];
    logic [127:0] exp_ct[$];

    int          cyc = 0, krdy_cnt = 0, drdy_cnt = 0, done_cnt = 0, rises = 0;
    int          drdy_cyc = 0, done_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    int          hi_width = 0, lo_gap = 0;
    logic [15:0] enc_prev = '0;
    logic        dvld_prev = 1'b0, trig_prev = 1'b0;

    initial forever begin
        @(negedge CLK);
        cyc++;
        if (core_krdy) krdy_cnt++;
        if (core_drdy) begin
            drdy_cnt++;
            drdy_cyc = cyc;
            chki("din sb nonempty", int'(exp_din.size() != 0), 1);
            if (exp_din.size() != 0) chk("core_din", core_din, exp_din.pop_front());
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (RSTn && enc_count != enc_prev && enc_count != 16'd0) begin
            chk("ct update after dvld", dvld_prev, 1'b1);
            chki("ct sb nonempty", int'(exp_ct.size() != 0), 1);
            if (exp_ct.size() != 0) chk("ct_last", ct_last, exp_ct.pop_front());
        end
        if (trigger && !trig_prev) begin
            rises++;
            lo_gap   = cyc - fall_cyc;
            rise_cyc = cyc;
            chk("trigger rises with drdy", core_drdy, 1'b1);
        end
        if (!trigger && trig_prev) begin
            fall_cyc = cyc;
            hi_width = cyc - rise_cyc;
        end
        enc_prev  = enc_count;
        dvld_prev = core_dvld;
        trig_prev = trigger;
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic sample();
        @(negedge CLK); #1;
    endtask

    task automatic start_run(input logic [127:0] k, input logic [127:0] p, input int n,
                             input logic ch, input int gap, input int n_din, input int n_ct);
        logic [127:0] cur, ct;
        cur = p;
        for (int i = 0; i < n_din; i++) begin
            exp_din.push_back(cur);
            ct = aes_model(k, cur);
            if (i < n_ct) exp_ct.push_back(ct);
            if (ch) cur = ct;
        end
        key = k; pt_seed = p; num_enc = 16'(n); chain_mode = ch; gap_cycles = 16'(gap);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            sample();
            n++;
        end
        chki(tag, done_cnt - d0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctl"}, {busy, done, trigger, err_timeout, core_en, core_krdy, core_drdy}, 7'd0);
        chk({tag, " enc_count"}, enc_count, 16'd0);
        chk({tag, " ct_last"}, ct_last, '0);
        chk({tag, " core_kin"}, core_kin, '0);
        chk({tag, " core_din"}, core_din, '0);
    endtask

    initial begin
        int d0, r0, k0, q0, base;

        // reset
        repeat (3) tick();
        sample();
        chk_all_zero("reset");
        RSTn = 1'b1;
        tick();

        // FIPS-197 single encryption
        d0 = done_cnt; r0 = rises;
        start_run(FIPS_KEY, FIPS_PT, 1, 1'b0, 0, 1, 1);
        sample();
        chk("busy after start", busy, 1'b1);
        chk("krdy after start", core_krdy, 1'b1);
        wait_done(100, "fips done");
        chk("fips ct_last", ct_last, FIPS_CT);
        chk("fips enc_count", enc_count, 16'd1);
        repeat (3) sample();
        chki("fips single done", done_cnt - d0, 1);
        chki("fips one trigger", rises - r0, 1);
        chki("trigger width", hi_width, 5);
        chk("idle after done", busy, 1'b0);

        // chained, 3 encryptions, gap 5
        r0 = rises;
        start_run(FIPS_KEY, FIPS_PT, 3, 1'b1, 5, 3, 3);
        wait_done(300, "chain done");
        chk("chain enc_count", enc_count, 16'd3);
        chki("chain triggers", rises - r0, 3);
        chki("chain low gap", lo_gap, 6);
        chki("chain queues drained", exp_din.size() + exp_ct.size(), 0);

        // num_enc = 0
        sample();
        k0 = krdy_cnt; q0 = drdy_cnt;
        start_run(FIPS_KEY, FIPS_PT, 0, 1'b0, 0, 0, 0);
        sample();
        chk("zero-run done", done, 1'b1);
        chk("zero-run enc_count", enc_count, 16'd0);
        sample();
        chk("zero-run back to idle", busy, 1'b0);
        chki("zero-run no krdy", krdy_cnt - k0, 0);
        chki("zero-run no drdy", drdy_cnt - q0, 0);

        // stalled core trips the watchdog
        stall = 1'b1;
        start_run(128'hdeadbeef, 128'h1234, 1, 1'b0, 0, 1, 0);
        wait_done(100, "timeout done");
        chk("err_timeout set", err_timeout, 1'b1);
        chki("data_wait cycles", done_cyc - drdy_cyc, 16);
        chk("timeout enc_count", enc_count, 16'd0);
        stall = 1'b0;
        sample();

        // dvld on the expiry cycle is accepted
        lat = 14;
        start_run(128'hdeadbeef, 128'h5678, 1, 1'b0, 0, 1, 1);
        sample();
        chk("err cleared by start", err_timeout, 1'b0);
        wait_done(100, "edge done");
        chk("edge no error", err_timeout, 1'b0);
        chk("edge enc_count", enc_count, 16'd1);
        lat = 3;
        sample();

        // abort in DATA_WAIT of the 2nd of 4
        d0 = done_cnt;
        base = drdy_cnt;
        start_run(128'h0f0e0d0c, 128'habcdef, 4, 1'b0, 2, 4, 4);
        for (int i = 0; i < 300 && drdy_cnt < base + 2; i++) sample();
        chki("2nd drdy seen", drdy_cnt - base, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sample();
        chk("abort idle", busy, 1'b0);
        chk("abort trigger", trigger, 1'b0);
        chk("abort enc_count", enc_count, 16'd1);
        chki("abort din left", exp_din.size(), 2);
        chki("abort ct left", exp_ct.size(), 3);
        exp_din.delete();
        exp_ct.delete();
        repeat (10) sample();
        chki("abort no done", done_cnt - d0, 0);

        // fresh run after abort, chained with no gap
        start_run(FIPS_KEY, 128'h55aa55aa, 2, 1'b1, 0, 2, 2);
        wait_done(200, "post-abort done");
        chk("post-abort enc_count", enc_count, 16'd2);
        chki("post-abort queues drained", exp_din.size() + exp_ct.size(), 0);
        sample();

        // start while busy ignored, then reset mid-GAP
        d0 = done_cnt;
        start_run(FIPS_KEY, FIPS_PT, 3, 1'b0, 20, 3, 3);
        for (int i = 0; i < 200 && enc_count != 16'd1; i++) sample();
        chk("reached gap", enc_count, 16'd1);
        key = '1; num_enc = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        sample();
        chk("busy start ignored", busy, 1'b1);
        chk("kin held", core_kin, FIPS_KEY);
        chki("busy start no done", done_cnt - d0, 0);
        RSTn = 1'b0;
        tick();
        sample();
        chk_all_zero("mid-gap reset");
        exp_din.delete();
        exp_ct.delete();
        RSTn = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
